shift_add_multiplier: RTL and testbench

- Iterative shift-add multiplier that rebuilds a dividend as product = multiplicand_in * multiplier_in + addend_in, one multiplier bit per cycle.
- It is the inverse of the team's divider. Feeding it the divider's quotient, divisor and remainder must reproduce the original dividend.
- It sits beside the divider in the card-tracking arithmetic path. It serves as a reconstruction/self-check unit and as a general small multiplier.
- Handshake is single-transaction: valid-in/busy, then a one-cycle valid-out pulse.

---
 rtl/shift_add_multiplier_pkg.sv | 24 ++
 rtl/shift_add_multiplier.sv | 104 ++++++++++
 tb/tb_shift_add_multiplier.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared arithmetic definitions for the divider / shift-add multiplier pair.
// Holds the common iteration state encoding and the width helpers, so that both
// blocks size their counters and products the same way.
package shift_add_multiplier_pkg;

    // Two-state iteration control shared by the divider and the multiplier
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arith_state_e;

    // Iteration counter width: enough bits to count WIDTH steps, never below one bit
    function automatic int counterWidth(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

    // Full-precision product width for two WIDTH-bit unsigned operands
    function automatic int productWidth(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier computing product = A * B + addend, one bit of B
// per clock. Used as the inverse of the divider: feeding it quotient, divisor and
// remainder rebuilds the dividend, and error_out flags triples that the divider
// could never have produced or whose reconstruction does not fit in WIDTH bits.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [WIDTH-1:0]           multiplicand_in,
    input  logic [WIDTH-1:0]           multiplier_in,
    input  logic [WIDTH-1:0]           addend_in,
    input  logic                       data_valid_in,
    output logic [productWidth(WIDTH)-1:0] product_out,
    output logic                       data_valid_out,
    output logic                       error_out,
    output logic                       busy_out
);

    localparam int PW = productWidth(WIDTH);
    localparam int CW = counterWidth(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    arith_state_e       r_state;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_chk;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_product;
    logic               r_validOut;
    logic               r_error;
    logic               r_busy;

    logic [PW-1:0]      w_accNext;
    logic               w_rangeErr;

    // Accumulator value after this iteration's conditional add of the shifted multiplicand
    always_comb begin
        w_accNext = r_acc;
        if (r_mplier[0]) begin
            w_accNext = r_acc + r_mcand;
        end
    end

    // The reconstructed value overflows WIDTH bits when any upper product bit is set
    assign w_rangeErr = |w_accNext[PW-1:WIDTH];

    // Transaction control: accept in IDLE, iterate WIDTH times in RUN, then pulse the result
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_chk      <= 1'b0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_validOut <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_validOut <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_valid_in) begin
                        r_state  <= RUN;
                        r_acc    <= {{WIDTH{1'b0}}, addend_in};
                        r_mcand  <= {{WIDTH{1'b0}}, multiplicand_in};
                        r_mplier <= multiplier_in;
                        r_chk    <= (addend_in >= multiplier_in);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state    <= IDLE;
                        r_product  <= w_accNext;
                        r_validOut <= 1'b1;
                        r_error    <= r_chk | w_rangeErr;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign product_out    = r_product;
    assign data_valid_out = r_validOut;
    assign error_out      = r_error;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed testbench for shift_add_multiplier (WIDTH=9): divider-inverse
// reconstruction, range and remainder error flags, back-to-back drops while busy,
// reset mid-transaction, and a sampled divider round trip.
module tb_shift_add_multiplier;

    localparam int WIDTH = 9;
    localparam int PW    = 2 * WIDTH;

    logic               clk_in;
    logic               rst_in;
    logic [WIDTH-1:0]   multiplicand_in;
    logic [WIDTH-1:0]   multiplier_in;
    logic [WIDTH-1:0]   addend_in;
    logic               data_valid_in;
    logic [PW-1:0]      product_out;
    logic               data_valid_out;
    logic               error_out;
    logic               busy_out;

    int assertCount = 0;
    int failCount   = 0;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .addend_in       (addend_in),
        .data_valid_in   (data_valid_in),
        .product_out     (product_out),
        .data_valid_out  (data_valid_out),
        .error_out       (error_out),
        .busy_out        (busy_out)
    );

    // 10 ns free-running clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle just after it
    task automatic stepEdge();
        @(posedge clk_in);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one operand triple for a single accept edge, then drop valid
    task automatic applyStimulus(input int a, input int b, input int add);
        multiplicand_in = WIDTH'(a);
        multiplier_in   = WIDTH'(b);
        addend_in       = WIDTH'(add);
        data_valid_in   = 1'b1;
        stepEdge();
        data_valid_in   = 1'b0;
    endtask

    // Full transaction: accept, wait (bounded) for the pulse, check latency, result and hold
    task automatic runTxn(input string tag, input int a, input int b, input int add,
                          input int expProduct, input int expError);
        int cycles;
        int busyCnt;
        applyStimulus(a, b, add);
        cycles  = 0;
        busyCnt = 0;
        while (!data_valid_out && cycles < 20) begin
            if (busy_out) busyCnt++;
            stepEdge();
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, WIDTH);
        checkOutput({tag, "_busyCycles"}, busyCnt, WIDTH);
        checkOutput({tag, "_validOut"}, {31'd0, data_valid_out}, 1);
        checkOutput({tag, "_product"}, {14'd0, product_out}, expProduct);
        checkOutput({tag, "_error"}, {31'd0, error_out}, expError);
        checkOutput({tag, "_busyDone"}, {31'd0, busy_out}, 0);
        stepEdge();
        checkOutput({tag, "_pulseEnd"}, {31'd0, data_valid_out}, 0);
        checkOutput({tag, "_productHeld"}, {14'd0, product_out}, expProduct);
        checkOutput({tag, "_errorHeld"}, {31'd0, error_out}, expError);
    endtask

    // Main directed sequence
    initial begin
        int pulses;
        int dividend;
        int divisor;
        int ba;
        int bb;
        int badd;
        int bexp;

        rst_in          = 1'b1;
        multiplicand_in = '0;
        multiplier_in   = '0;
        addend_in       = '0;
        data_valid_in   = 1'b0;
        stepEdge();
        stepEdge();
        checkOutput("reset_product", {14'd0, product_out}, 0);
        checkOutput("reset_valid", {31'd0, data_valid_out}, 0);
        checkOutput("reset_error", {31'd0, error_out}, 0);
        checkOutput("reset_busy", {31'd0, busy_out}, 0);
        rst_in = 1'b0;
        stepEdge();

        $display("[TB] divider inverse and error flags");
        runTxn("inverse", 23, 10, 7, 237, 0);
        runTxn("overflow", 511, 511, 0, 261121, 1);
        runTxn("fit511", 51, 10, 1, 511, 0);
        runTxn("badRemainder", 5, 4, 4, 24, 1);
        runTxn("zeroDivisor", 0, 0, 0, 0, 1);

        $display("[TB] back-to-back with valid held high");
        for (int i = 0; i < 30; i++) begin
            multiplicand_in = WIDTH'((i * 37 + 5) % 512);
            multiplier_in   = WIDTH'((i * 11 + 3) % 512);
            addend_in       = WIDTH'((i * 7) % 512);
            data_valid_in   = 1'b1;
            stepEdge();
            checkOutput("b2b_valid", {31'd0, data_valid_out}, ((i % 10) == 9) ? 1 : 0);
            checkOutput("b2b_busy", {31'd0, busy_out}, ((i % 10) == 9) ? 0 : 1);
            if ((i % 10) == 9) begin
                ba   = ((i - 9) * 37 + 5) % 512;
                bb   = ((i - 9) * 11 + 3) % 512;
                badd = ((i - 9) * 7) % 512;
                bexp = ba * bb + badd;
                checkOutput("b2b_product", {14'd0, product_out}, bexp);
                checkOutput("b2b_error", {31'd0, error_out},
                            ((badd >= bb) || (bexp > 511)) ? 1 : 0);
            end
        end
        data_valid_in = 1'b0;
        stepEdge();

        $display("[TB] reset in the middle of a transaction");
        applyStimulus(23, 10, 7);
        for (int i = 0; i < 4; i++) stepEdge();
        rst_in          = 1'b1;
        data_valid_in   = 1'b1;
        stepEdge();
        checkOutput("midReset_product", {14'd0, product_out}, 0);
        checkOutput("midReset_valid", {31'd0, data_valid_out}, 0);
        checkOutput("midReset_error", {31'd0, error_out}, 0);
        checkOutput("midReset_busy", {31'd0, busy_out}, 0);
        rst_in        = 1'b0;
        data_valid_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            stepEdge();
            if (data_valid_out) pulses++;
        end
        checkOutput("midReset_noPulse", pulses, 0);
        runTxn("afterReset", 3, 7, 2, 23, 0);

        $display("[TB] divider round trip");
        runTxn("rt_511_1", 511, 1, 0, 511, 0);
        runTxn("rt_0_511", 0, 511, 0, 0, 0);
        runTxn("rt_510_511", 0, 511, 510, 510, 0);
        for (int i = 0; i < 120; i++) begin
            dividend = $urandom_range(0, 511);
            divisor  = $urandom_range(1, 511);
            runTxn("roundTrip", dividend / divisor, divisor, dividend % divisor, dividend, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
